ram_master: RTL and testbench

RAM_MASTER -- requirements
Module: ram_master

---
 rtl/ram_pkg.sv | 37 +++
 rtl/ram_master_bus_drv.sv | 17 +
 rtl/ram_master.sv | 159 +++++++++++++++
 tb/tb_ram_master.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg -- shared types and constants for the ram_master codebase slice.
//   state_t    : burst controller states
//   ram_ctrl_t : bundle of the three RAM strobes (cs / oa / wa)
//   ctrl_for() : strobe pattern a given state presents to the RAM
package ram_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_PULSE,
    RD_ISSUE,
    RD_HOLD
  } state_t;

  typedef struct packed {
    logic cs;
    logic oa;
    logic wa;
  } ram_ctrl_t;

  // Only the two RAM-access states strobe the RAM; write and read enables
  // are mutually exclusive by construction.
  function automatic ram_ctrl_t ctrl_for(input state_t s);
    ram_ctrl_t c;
    c = '{cs: 1'b0, oa: 1'b0, wa: 1'b0};
    case (s)
      WR_PULSE: c = '{cs: 1'b1, oa: 1'b0, wa: 1'b1};
      RD_ISSUE: c = '{cs: 1'b1, oa: 1'b1, wa: 1'b0};
      default:  c = '{cs: 1'b0, oa: 1'b0, wa: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram_master_bus_drv.sv
// bus_drv -- tri-state driver for the shared RAM data bus.
//   data   : value to place on the bus
//   enable : 1 drives data onto bus, 0 releases it (high-Z)
//   bus    : shared bidirectional bus
module bus_drv
  import ram_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic [W-1:0] data,
  input  logic         enable,
  inout  wire  [W-1:0] bus
);

  assign bus = enable ? data : {W{1'bz}};

endmodule

// File: rtl/ram_master.sv
// ram_master -- burst controller for an asynchronous SRAM with a shared
// bidirectional data bus.
//   clk, rst_n                      : clock, async active-low reset
//   cmd_valid/cmd_ready             : command handshake
//   cmd_write, cmd_addr, cmd_len    : burst direction, start address, beats-1
//   wr_valid/wr_ready/wr_data       : write-data stream (one word per beat)
//   rd_valid/rd_ready/rd_data       : read-data stream (one word per beat)
//   busy                            : high whenever a burst is in progress
//   ram_addr, ram_cs, ram_oa, ram_wa: registered RAM address and strobes
//   ram_bus                         : shared RAM data bus (driven only in WR_PULSE)
module ram_master
  import ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_cs,
  output logic              ram_oa,
  output logic              ram_wa,
  inout  wire  [DATA_W-1:0] ram_bus
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] beats_q;     // beats remaining after the current one
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  ram_ctrl_t         ctrl_q;

  logic              last_beat;
  logic              cmd_fire;
  logic              wr_fire;
  logic              rd_fire;
  logic              beat_done;
  logic              bus_en;

  assign last_beat = (beats_q == '0);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation order cannot change behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid) state_d = cmd_write ? WR_WAIT : RD_ISSUE;
      WR_WAIT:  if (wr_valid)  state_d = WR_PULSE;
      WR_PULSE: state_d = last_beat ? IDLE : WR_WAIT;
      RD_ISSUE: state_d = RD_HOLD;
      RD_HOLD:  if (rd_ready)  state_d = last_beat ? IDLE : RD_ISSUE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------
  always_comb begin
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    bus_en    = 1'b0;
    case (state_q)
      IDLE:     begin cmd_ready = 1'b1; busy = 1'b0; end
      WR_WAIT:  wr_ready = 1'b1;
      WR_PULSE: bus_en   = 1'b1;
      default:  ;
    endcase
  end

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign wr_fire   = wr_valid & wr_ready;
  // rd_valid is always set in RD_HOLD, so ready alone completes the beat.
  assign rd_fire   = (state_q == RD_HOLD) & rd_ready;
  assign beat_done = (state_q == WR_PULSE) | rd_fire;

  // ---------------------------------------------------------------------
  // Address / beat counters and data registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else if (cmd_fire) begin
      addr_q  <= cmd_addr;
      beats_q <= cmd_len;
    end else if (beat_done) begin
      // Natural ADDR_W-bit overflow gives the wrap to address 0.
      addr_q  <= addr_q + ADDR_W'(1);
      beats_q <= beats_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wdata_q <= '0;
    else if (wr_fire) wdata_q <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (state_q == RD_ISSUE) begin
      // The RAM has been driving the bus for the whole RD_ISSUE cycle.
      rd_data_q  <= ram_bus;
      rd_valid_q <= 1'b1;
    end else if (rd_fire) begin
      rd_valid_q <= 1'b0;
    end
  end

  // Strobes are registered from the next state so they are high for exactly
  // the cycles spent in WR_PULSE / RD_ISSUE, with no decode glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '{cs: 1'b0, oa: 1'b0, wa: 1'b0};
    else        ctrl_q <= ctrl_for(state_d);
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ram_addr = addr_q;
  assign ram_cs   = ctrl_q.cs;
  assign ram_oa   = ctrl_q.oa;
  assign ram_wa   = ctrl_q.wa;

  bus_drv #(.W(DATA_W)) u_bus_drv (
    .data   (wdata_q),
    .enable (bus_en),
    .bus    (ram_bus)
  );

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master -- self-checking bench for ram_master.
// A behavioural RAM sits on the shared bus; ref_mem is the bench's view of
// what the RAM must contain. Read expectations are queued when a read
// command is issued and compared by a monitor on each rd handshake.
module tb_ram_master;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic          ram_cs;
  logic          ram_oa;
  logic          ram_wa;
  wire  [DW-1:0] ram_bus;

  int checks = 0;
  int errors = 0;
  int wa_count = 0;
  int rd_mode = 0;            // 0 random rd_ready, 1 hold low, 2 hold high

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q   [$];
  logic [DW-1:0] wq      [$];

  ram_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .ram_addr  (ram_addr),
    .ram_cs    (ram_cs),
    .ram_oa    (ram_oa),
    .ram_wa    (ram_wa),
    .ram_bus   (ram_bus)
  );

  // Behavioural asynchronous RAM: drives the bus while output-enabled,
  // captures on the rising edge that closes a write strobe.
  assign ram_bus = (ram_cs && ram_oa && !ram_wa) ? mem[ram_addr] : {DW{1'bz}};

  always @(posedge clk) begin
    if (ram_cs && ram_wa) mem[ram_addr] <= ram_bus;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // rd_ready driver
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rd_mode)
        1:       rd_ready = 1'b0;
        2:       rd_ready = 1'b1;
        default: rd_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Protocol monitor and read scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("wa_oa_exclusive", {31'd0, ram_wa & ram_oa}, 32'd0);
      check("cmd_ready_while_busy", {31'd0, cmd_ready & busy}, 32'd0);
      if (ram_wa) wa_count++;
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_beat", 32'd1, 32'd0);
        end else begin
          check("rd_data", {24'd0, rd_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  // Called away from a clock edge; returns 1 time unit after the handshake edge.
  task automatic send_cmd(input logic w, input int a, input int l);
    int n;
    cmd_write = w;
    cmd_addr  = AW'(a);
    cmd_len   = AW'(l);
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("cmd_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int stall);
    int n;
    wr_valid = 1'b0;
    repeat (stall) begin
      @(posedge clk);
      #1;
    end
    wr_data  = d;
    wr_valid = 1'b1;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) check("wr_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check("burst_done_timeout", 32'd1, 32'd0);
  endtask

  // Write burst of l+1 words taken from wq; ref_mem follows the address wrap.
  task automatic do_write(input int a, input int l, input int stall_max);
    logic [DW-1:0] d;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= l; i++) begin
      d = wq.pop_front();
      send_word(d, $urandom_range(0, stall_max));
      ref_mem[(a + i) % DEPTH] = d;
    end
    wait_done();
  endtask

  task automatic do_read(input int a, input int l);
    for (int i = 0; i <= l; i++) exp_q.push_back(ref_mem[(a + i) % DEPTH]);
    send_cmd(1'b0, a, l);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    check({tag, "_wr_ready"},  {31'd0, wr_ready},  32'd0);
    check({tag, "_rd_valid"},  {31'd0, rd_valid},  32'd0);
    check({tag, "_rd_data"},   {24'd0, rd_data},   32'd0);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_ram_addr"},  {28'd0, ram_addr},  32'd0);
    check({tag, "_ram_ctrl"},  {29'd0, ram_cs, ram_oa, ram_wa}, 32'd0);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, n, w, a, l;
    logic [DW-1:0] d3;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill the whole RAM in one burst (len all-ones = 2^ADDR_W beats).
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) wq.push_back(DW'($urandom));
    do_write(0, DEPTH - 1, 1);
    do_read(0, DEPTH - 1);
    wait_done();

    // Single write then read with latency check.
    wq.push_back(8'hA5);
    do_write(3, 0, 0);
    rd_mode = 2;
    do_read(3, 0);
    @(negedge clk);
    check("lat_cycle1_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("lat_cycle1_ram_oa",   {31'd0, ram_oa},   32'd1);
    @(negedge clk);
    check("lat_cycle2_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("lat_cycle2_rd_data",  {24'd0, rd_data},  32'hA5);
    wait_done();
    rd_mode = 0;

    // Write burst wrapping past the top address.
    wq.push_back(8'h11);
    wq.push_back(8'h22);
    wq.push_back(8'h33);
    wq.push_back(8'h44);
    do_write(14, 3, 0);
    check("wrap_mem14", {24'd0, mem[14]}, 32'h11);
    check("wrap_mem15", {24'd0, mem[15]}, 32'h22);
    check("wrap_mem0",  {24'd0, mem[0]},  32'h33);
    check("wrap_mem1",  {24'd0, mem[1]},  32'h44);
    do_read(14, 3);
    wait_done();

    // Read backpressure: rd_ready low for 5 cycles on the first beat.
    rd_mode = 1;
    do_read(14, 3);
    n = 0;
    while (!rd_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("stall_rd_valid_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rd_valid", {31'd0, rd_valid}, 32'd1);
      check("stall_rd_data",  {24'd0, rd_data},  32'h11);
      check("stall_ram_cs",   {31'd0, ram_cs},   32'd0);
    end
    rd_mode = 2;
    @(posedge clk);     // rd_ready rises just after this edge
    @(negedge clk);     // monitor takes the first beat here
    @(posedge clk);     // handshake
    @(negedge clk);
    check("stall_next_issue_cs", {31'd0, ram_cs}, 32'd1);
    check("stall_next_issue_oa", {31'd0, ram_oa}, 32'd1);
    rd_mode = 0;
    wait_done();

    // Write stall: no strobe while waiting, one strobe per accepted word.
    send_cmd(1'b1, 5, 1);
    c0 = wa_count;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("wstall_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("wstall_no_pulse", wa_count - c0, 32'd0);
    send_word(8'h5C, 0);
    ref_mem[5] = 8'h5C;
    send_word(8'hC5, 2);
    ref_mem[6] = 8'hC5;
    wait_done();
    check("wstall_pulse_count", wa_count - c0, 32'd2);
    do_read(5, 1);
    wait_done();

    // Reset in the middle of a 4-beat write burst: beat 3 latched but not pulsed.
    send_cmd(1'b1, 8, 3);
    send_word(8'hD1, 0);
    ref_mem[8] = 8'hD1;
    send_word(8'hD2, 0);
    ref_mem[9] = 8'hD2;
    d3 = ref_mem[10] ^ 8'hFF;
    send_word(d3, 0);    // returns with the DUT in WR_PULSE for beat 3
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midburst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("post_reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    do_read(8, 3);
    check("post_reset_accept_first_edge", {31'd0, busy}, 32'd1);
    wait_done();

    // Randomized traffic against the reference memory.
    for (int k = 0; k < 40; k++) begin
      w = $urandom_range(0, 1);
      a = $urandom_range(0, DEPTH - 1);
      l = ($urandom_range(0, 7) == 0) ? DEPTH - 1 : $urandom_range(0, 4);
      if (w != 0) begin
        for (int i = 0; i <= l; i++) wq.push_back(DW'($urandom));
        do_write(a, l, 2);
      end else begin
        do_read(a, l);
        wait_done();
      end
    end

    repeat (3) @(posedge clk);
    check("final_exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
